ifetch_pq: RTL and testbench

- Instruction-fetch stage with a prefetch queue; sits directly upstream of ID.
- Issues sequential word reads to synchronous instruction memory and buffers returned words with their addresses.
- Presents buffered words to ID under a valid/stall handshake.
- Redirects on branch_i/baddr_i from EX: flushes queued and in-flight fetches.

---
 rtl/ifetch_pq_pkg.sv | 11 +
 rtl/ifq_fifo.sv | 73 +++++++
 rtl/ifetch_pq.sv | 126 ++++++++++++
 tb/tb_ifetch_pq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pq_pkg.sv
// Shared defaults for the instruction-fetch prefetch queue.
// Holds the default address/instruction widths, queue depth and reset fetch
// address used by ifetch_pq and its FIFO.
package ifetch_pq_pkg;

  localparam int unsigned ADDR_W_DEF         = 16;
  localparam int unsigned INST_W_DEF         = 16;
  localparam int unsigned DEPTH_DEF          = 2;
  localparam logic [15:0] RESET_ADDR_DEF     = 16'h0000;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry FIFO holding {addr, inst} fetch entries.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   push_i       write data_i at the tail
//   pop_i        drop the head entry
//   flush_i      empty the queue; takes priority over push and pop
//   data_i       entry to write
//   count_o      number of valid entries (0..DEPTH)
//   head_o       entry at the head (meaningful while count_o != 0)
module ifq_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             data_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [W-1:0]             head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_pq.sv
// ifetch_pq: instruction-fetch stage with a prefetch queue, upstream of ID.
// Issues sequential word reads to a synchronous instruction memory (data one
// cycle after the request), buffers returned words with their addresses and
// hands them to ID under a valid/stall handshake. A branch from EX flushes
// queued and in-flight fetches and restarts fetch at the target.
// Build option: define IFETCH_BYPASS_EN to forward a response straight to ID
// when the queue is empty (one cycle lower fetch and redirect latency).
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   branch_i      redirect request; baddr_i is the target
//   req_o/addr_o  memory read enable and address
//   mem_data_i    read data for the previous cycle's request
//   v_o/stall_i   handshake to ID (transfer when v_o & ~stall_i)
//   inst_o        head instruction; origaddr_o is its address
module ifetch_pq
  import ifetch_pq_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       INST_W     = INST_W_DEF,
  parameter int unsigned       DEPTH      = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] baddr_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [INST_W-1:0] mem_data_i,
  output logic              v_o,
  input  logic              stall_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] origaddr_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] reqaddr_q, reqaddr_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic [CNT_W:0]    occ;
  logic              resp;
  logic              bypass;
  logic              pop;
  logic              fifo_pop;
  logic              push;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .flush_i (branch_i),
    .data_i  ({reqaddr_q, mem_data_i}),
    .count_o (count),
    .head_o  (head)
  );

  // Handshake, queue control and issue decision.
  always_comb begin
    // A response is usable only if not killed and not overtaken by a redirect.
    resp = rst & inflight_q & ~kill_q & ~branch_i;
`ifdef IFETCH_BYPASS_EN
    bypass = resp & (count == '0);
`else
    bypass = 1'b0;
`endif
    v_o = rst & (bypass | (count != '0));

    {origaddr_o, inst_o} = head;
    if (!rst) begin
      {origaddr_o, inst_o} = '0;
    end else if (bypass) begin
      {origaddr_o, inst_o} = {reqaddr_q, mem_data_i};
    end

    pop      = v_o & ~stall_i;
    fifo_pop = pop & ~bypass;
    // A bypassed word that ID accepts never enters the queue.
    push     = resp & ~(bypass & pop);

    // Issue only when a slot is guaranteed for the response.
    occ   = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q);
    req_o = rst & ~branch_i &
            ((occ < (CNT_W+1)'(DEPTH)) | (pop & (occ == (CNT_W+1)'(DEPTH))));
    addr_o = pc_q;
  end

  // Fetch PC, outstanding-request tracking and redirect.
  always_comb begin
    pc_d       = pc_q;
    reqaddr_d  = reqaddr_q;
    inflight_d = req_o;
    kill_d     = 1'b0;
    if (branch_i) begin
      pc_d   = baddr_i;
      kill_d = inflight_q;
    end else if (req_o) begin
      pc_d      = pc_q + ADDR_W'(1);
      reqaddr_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_ADDR;
      reqaddr_q  <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      reqaddr_q  <= reqaddr_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

endmodule

// File: tb/tb_ifetch_pq.sv
// Testbench for ifetch_pq: directed vector table, hand-written redirect/wrap/
// reset sequences, then randomized stall/branch/reset traffic checked against
// a queue-level reference model and an accepted-stream ordering check.
module tb_ifetch_pq;

  localparam int unsigned    AW      = 16;
  localparam int unsigned    IW      = 16;
  localparam int unsigned    DEPTH   = 2;
  localparam logic [AW-1:0]  RST_A   = 16'h0000;
  localparam logic [IW-1:0]  MEM_OFS = 16'h1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          branch_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [AW-1:0] baddr_i = '0;
  logic [IW-1:0] mem_data_i = '0;
  logic          req_o;
  logic          v_o;
  logic [AW-1:0] addr_o;
  logic [AW-1:0] origaddr_o;
  logic [IW-1:0] inst_o;

  ifetch_pq #(
    .ADDR_W     (AW),
    .INST_W     (IW),
    .DEPTH      (DEPTH),
    .RESET_ADDR (RST_A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .branch_i   (branch_i),
    .baddr_i    (baddr_i),
    .req_o      (req_o),
    .addr_o     (addr_o),
    .mem_data_i (mem_data_i),
    .v_o        (v_o),
    .stall_i    (stall_i),
    .inst_o     (inst_o),
    .origaddr_o (origaddr_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: queue of buffered fetch addresses plus one
  // outstanding request.
  logic [AW-1:0] m_q[$];
  logic          m_infl    = 1'b0;
  logic          m_kill    = 1'b0;
  logic [AW-1:0] m_pc      = RST_A;
  logic [AW-1:0] m_reqaddr = '0;
  logic [AW-1:0] m_next    = RST_A;
  logic          model_on  = 1'b0;

  // Memory model: last cycle's request
  logic          mem_req  = 1'b0;
  logic [AW-1:0] mem_addr = '0;

  typedef struct {
    logic          stall;
    logic          branch;
    logic [AW-1:0] baddr;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic          e_v;
    logic [AW-1:0] e_orig;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_infl = 1'b0;
    m_kill = 1'b0;
    m_pc   = RST_A;
    m_next = RST_A;
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, check, advance model.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [AW-1:0] ba);
    int            sz;
    int            occ;
    logic          resp;
    logic          byp;
    logic          ev;
    logic          pop;
    logic          ereq;
    logic [AW-1:0] eorig;
    @(negedge clk);
    rst      = r;
    stall_i  = s;
    branch_i = b;
    baddr_i  = ba;
    mem_data_i = mem_req ? (IW'(mem_addr) + MEM_OFS) : IW'($urandom);
    #1;
    if (model_on) begin
      sz   = m_q.size();
      resp = r & m_infl & ~m_kill & ~b;
      byp  = 1'b0;
`ifdef IFETCH_BYPASS_EN
      byp  = resp & (sz == 0);
`endif
      ev    = r & (byp | (sz != 0));
      eorig = byp ? m_reqaddr : ((sz != 0) ? m_q[0] : '0);
      pop   = ev & ~s;
      occ   = sz + (m_infl ? 1 : 0);
      ereq  = r & ~b & ((occ < int'(DEPTH)) | (pop & (occ == int'(DEPTH))));

      chk("req_o", 16'(req_o), 16'(ereq));
      chk("addr_o", addr_o, m_pc);
      chk("v_o", 16'(v_o), 16'(ev));
      if (ev) begin
        chk("origaddr_o", origaddr_o, eorig);
        chk("inst_o", inst_o, eorig + MEM_OFS);
      end
      if (!r) begin
        chk("rst_inst_o", inst_o, 16'h0000);
        chk("rst_origaddr_o", origaddr_o, 16'h0000);
      end
      // Accepted words must form a gap-free, duplicate-free sequential stream.
      if (pop) begin
        chk("stream_order", origaddr_o, m_next);
        m_next = m_next + 16'd1;
      end

      if (!r) begin
        model_reset();
      end else if (b) begin
        m_q.delete();
        m_pc   = ba;
        m_kill = m_infl;
        m_infl = 1'b0;
        m_next = ba;
      end else begin
        if (pop && !byp) void'(m_q.pop_front());
        if (resp && !(byp && pop)) m_q.push_back(m_reqaddr);
        if (ereq) begin
          m_reqaddr = m_pc;
          m_pc      = m_pc + 16'd1;
        end
        m_infl = ereq;
        m_kill = 1'b0;
      end
    end
    mem_req  = req_o;
    mem_addr = addr_o;
  endtask

  task automatic wait_valid(input string nm, input logic [AW-1:0] exp);
    bit got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      got = v_o;
    end
    if (got) chk(nm, origaddr_o, exp);
    else begin
      n_total++;
      $display("FAIL %s: v_o never rose, got 0 required 1 within 8 cycles", nm);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic b, input logic [AW-1:0] ba,
                              input logic er, input logic [AW-1:0] ea,
                              input logic ev, input logic [AW-1:0] eo);
    vec_t v;
    v.stall = s; v.branch = b; v.baddr = ba;
    v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_orig = eo;
    return v;
  endfunction

  initial begin
    vec_t tbl[13];
    logic r;
    logic s;
    logic b;
    logic [AW-1:0] ba;

`ifdef IFETCH_BYPASS_EN
    tbl[0]  = mk(0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    tbl[1]  = mk(0, 0, 16'h0000, 1, 16'h0001, 1, 16'h0000);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0001);
    tbl[3]  = mk(1, 0, 16'h0000, 1, 16'h0003, 1, 16'h0002);
    tbl[4]  = mk(1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002);
    tbl[5]  = mk(1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002);
    tbl[6]  = mk(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002);
    tbl[7]  = mk(0, 0, 16'h0000, 1, 16'h0005, 1, 16'h0003);
    tbl[8]  = mk(0, 1, 16'h0040, 0, 16'h0006, 1, 16'h0004);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000);
    tbl[10] = mk(0, 0, 16'h0000, 1, 16'h0041, 1, 16'h0040);
    tbl[11] = mk(0, 0, 16'h0000, 1, 16'h0042, 1, 16'h0041);
    tbl[12] = mk(0, 0, 16'h0000, 1, 16'h0043, 1, 16'h0042);
`else
    tbl[0]  = mk(0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    tbl[1]  = mk(0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000);
    tbl[3]  = mk(1, 0, 16'h0000, 0, 16'h0003, 1, 16'h0001);
    tbl[4]  = mk(1, 0, 16'h0000, 0, 16'h0003, 1, 16'h0001);
    tbl[5]  = mk(1, 0, 16'h0000, 0, 16'h0003, 1, 16'h0001);
    tbl[6]  = mk(0, 0, 16'h0000, 1, 16'h0003, 1, 16'h0001);
    tbl[7]  = mk(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002);
    tbl[8]  = mk(0, 1, 16'h0040, 0, 16'h0005, 1, 16'h0003);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000);
    tbl[10] = mk(0, 0, 16'h0000, 1, 16'h0041, 0, 16'h0000);
    tbl[11] = mk(0, 0, 16'h0000, 1, 16'h0042, 1, 16'h0040);
    tbl[12] = mk(0, 0, 16'h0000, 1, 16'h0043, 1, 16'h0041);
`endif

    // Power-up reset; model takes over once state is defined.
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    model_on = 1'b1;

    // Directed vectors: start-up, stall back-pressure, redirect to 0x0040.
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, tbl[i].stall, tbl[i].branch, tbl[i].baddr);
      chk($sformatf("tbl%0d_req", i), 16'(req_o), 16'(tbl[i].e_req));
      chk($sformatf("tbl%0d_addr", i), addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_v", i), 16'(v_o), 16'(tbl[i].e_v));
      if (tbl[i].e_v) chk($sformatf("tbl%0d_orig", i), origaddr_o, tbl[i].e_orig);
      if (i == 0) begin
        chk("tbl0_inst_zero", inst_o, 16'h0000);
        chk("tbl0_orig_zero", origaddr_o, 16'h0000);
      end
    end

    // Branch while stalled with a response arriving: response dropped.
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 16'h1234);
    cycle(1'b1, 1'b1, 1'b0, '0);
    chk("brstall_v_low", 16'(v_o), 16'h0000);
    wait_valid("brstall_target", 16'h1234);

    // Sequential fetch across the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 16'hFFFE);
    wait_valid("wrap_fffe", 16'hFFFE);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("wrap_ffff_v", 16'(v_o), 16'h0001);
    chk("wrap_ffff", origaddr_o, 16'hFFFF);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("wrap_0000_v", 16'(v_o), 16'h0001);
    chk("wrap_0000", origaddr_o, 16'h0000);

    // Branch held several cycles: last target wins.
    cycle(1'b1, 1'b0, 1'b1, 16'h0100);
    cycle(1'b1, 1'b1, 1'b1, 16'h0200);
    cycle(1'b1, 1'b0, 1'b1, 16'h0300);
    wait_valid("held_branch", 16'h0300);

    // One-cycle reset mid-stream.
    repeat (4) cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("midrst_v", 16'(v_o), 16'h0000);
    chk("midrst_req", 16'(req_o), 16'h0000);
    chk("midrst_inst", inst_o, 16'h0000);
    chk("midrst_orig", origaddr_o, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("postrst_req", 16'(req_o), 16'h0001);
    chk("postrst_addr", addr_o, RST_A);
    chk("postrst_v", 16'(v_o), 16'h0000);
    wait_valid("postrst_first", RST_A);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(99) != 0);
      s  = ($urandom_range(99) < 35);
      b  = ($urandom_range(99) < 6);
      ba = AW'($urandom);
      if ($urandom_range(3) == 0) ba = 16'hFFFC | AW'($urandom_range(3));
      cycle(r, s, b, ba);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
